// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: drives the fetch PC into the program ROM and buffers fetched words for decode.
module instruction_fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h00400000,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [DATA_WIDTH-1:0] imem_address_o,
   input  logic [DATA_WIDTH-1:0] imem_instruction_i,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] redirect_pc_i,
   output logic                  if_valid_o,
   input  logic                  if_ready_i,
   output logic [DATA_WIDTH-1:0] if_instruction_o,
   output logic [DATA_WIDTH-1:0] if_pc_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   logic [DATA_WIDTH-1:0] fetch_pc;
   logic [DATA_WIDTH-1:0] pc_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] ins_mem [FIFO_DEPTH];
   logic [AW:0] count;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic pop, push;
   always_comb begin
      pop  = if_valid_o & if_ready_i & ~redirect_i;
      push = ~redirect_i & ((count < FULL) | pop);
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pc_mem[i]  <= '0;
            ins_mem[i] <= '0;
         end
      end else if (redirect_i) begin
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fetch_pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      end else begin
         if (push) begin
            pc_mem[wr_ptr]  <= fetch_pc;
            ins_mem[wr_ptr] <= imem_instruction_i;
            wr_ptr          <= wr_ptr + AW'(1);
            fetch_pc        <= fetch_pc + DATA_WIDTH'(4);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   assign imem_address_o   = fetch_pc;
   assign if_valid_o       = (count != '0);
   assign if_instruction_o = ins_mem[rd_ptr];
   assign if_pc_o          = pc_mem[rd_ptr];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of streaming, stall, redirect, wrap and reset behaviour.
module tb_instruction_fetch_unit;
   localparam logic [31:0] BASE = 32'h00400000;
   logic clk = 1'b0;
   logic reset, redirect_i, if_ready_i, if_valid_o;
   logic [31:0] imem_address_o, imem_instruction_i, redirect_pc_i, if_instruction_o, if_pc_o;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   function automatic logic [31:0] rom(input logic [31:0] a);
      logic [31:0] d;
      d = a - BASE;
      return d >> 2;
   endfunction
   assign imem_instruction_i = rom(imem_address_o);
   instruction_fetch_unit dut (
      .clk(clk), .reset(reset), .imem_address_o(imem_address_o), .imem_instruction_i(imem_instruction_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .if_valid_o(if_valid_o),
      .if_ready_i(if_ready_i), .if_instruction_o(if_instruction_o), .if_pc_o(if_pc_o)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      reset = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b0;
      step(); step();
      total++; if (imem_address_o !== BASE) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_address_o, BASE); end
      total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid_o); end
      total++; if (if_instruction_o !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", if_instruction_o); end
      total++; if (if_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", if_pc_o); end
   endtask
   task automatic test_stream();
      reset = 1'b1; if_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         total++; if (if_valid_o !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, if_valid_o); end
         total++; if (if_pc_o !== BASE + 32'(4*i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, if_pc_o, BASE + 32'(4*i)); end
         total++; if (if_instruction_o !== 32'(i)) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, if_instruction_o, 32'(i)); end
      end
   endtask
   task automatic test_stall();
      reset = 1'b0; step();
      reset = 1'b1; if_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (i >= 1) begin
            total++; if (imem_address_o !== BASE + 32'h8) begin bad++; $display("FAIL stall_addr[%0d] got=%h exp=%h", i, imem_address_o, BASE + 32'h8); end
         end
      end
      total++; if (if_valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", if_valid_o); end
      total++; if (if_pc_o !== BASE) begin bad++; $display("FAIL stall_head got=%h exp=%h", if_pc_o, BASE); end
      if_ready_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         total++; if (if_pc_o !== BASE + 32'(4*i)) begin bad++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, if_pc_o, BASE + 32'(4*i)); end
         total++; if (if_instruction_o !== 32'(i)) begin bad++; $display("FAIL drain_instr[%0d] got=%h exp=%h", i, if_instruction_o, 32'(i)); end
      end
   endtask
   task automatic test_redirect();
      redirect_i = 1'b1; redirect_pc_i = 32'h00400040;
      step();
      total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", if_valid_o); end
      total++; if (imem_address_o !== 32'h00400040) begin bad++; $display("FAIL redir_addr got=%h exp=00400040", imem_address_o); end
      redirect_i = 1'b0;
      step();
      total++; if (if_valid_o !== 1'b1) begin bad++; $display("FAIL redir_valid2 got=%b exp=1", if_valid_o); end
      total++; if (if_pc_o !== 32'h00400040) begin bad++; $display("FAIL redir_pc got=%h exp=00400040", if_pc_o); end
      total++; if (if_instruction_o !== 32'h10) begin bad++; $display("FAIL redir_instr got=%h exp=10", if_instruction_o); end
   endtask
   task automatic test_misalign();
      redirect_i = 1'b1; redirect_pc_i = 32'h00400043;
      step();
      total++; if (imem_address_o !== 32'h00400040) begin bad++; $display("FAIL misalign_addr got=%h exp=00400040", imem_address_o); end
      redirect_i = 1'b0;
      step();
      total++; if (if_pc_o !== 32'h00400040) begin bad++; $display("FAIL misalign_pc got=%h exp=00400040", if_pc_o); end
   endtask
   task automatic test_wrap();
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFFFFFC;
      step();
      total++; if (imem_address_o !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_address_o); end
      redirect_i = 1'b0;
      step();
      total++; if (if_pc_o !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_pc0 got=%h exp=fffffffc", if_pc_o); end
      total++; if (if_instruction_o !== 32'h3FEFFFFF) begin bad++; $display("FAIL wrap_instr0 got=%h exp=3fefffff", if_instruction_o); end
      total++; if (imem_address_o !== 32'h0) begin bad++; $display("FAIL wrap_addr1 got=%h exp=0", imem_address_o); end
      step();
      total++; if (if_pc_o !== 32'h0) begin bad++; $display("FAIL wrap_pc1 got=%h exp=0", if_pc_o); end
      total++; if (if_instruction_o !== 32'h3FF00000) begin bad++; $display("FAIL wrap_instr1 got=%h exp=3ff00000", if_instruction_o); end
   endtask
   task automatic test_reset_mid();
      step();
      reset = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h00400040;
      step();
      total++; if (if_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", if_valid_o); end
      total++; if (imem_address_o !== BASE) begin bad++; $display("FAIL rstmid_addr got=%h exp=%h", imem_address_o, BASE); end
      total++; if (if_pc_o !== 32'h0) begin bad++; $display("FAIL rstmid_pc got=%h exp=0", if_pc_o); end
      total++; if (if_instruction_o !== 32'h0) begin bad++; $display("FAIL rstmid_instr got=%h exp=0", if_instruction_o); end
      reset = 1'b1; redirect_i = 1'b0;
      step();
      total++; if (if_pc_o !== BASE) begin bad++; $display("FAIL rstmid_restart got=%h exp=%h", if_pc_o, BASE); end
   endtask
   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_misalign();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
